// File: rtl/upload_pkg.sv
// upload_pkg: constants, FSM states and packet field positions shared by the packer and the host decoder.
package upload_pkg;
    localparam logic [15:0] HDR_SYNC_DEF = 16'hA55A;
    localparam logic [15:0] TRL_SYNC_DEF = 16'h5AA5;
    localparam int SYNC_LSB = 48;
    localparam int CNT_LSB  = 32;
    localparam int LEN_LSB  = 16;
    localparam int CSUM_LSB = 0;
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, TRAILER, DONE} state_t;
    function automatic logic [63:0] header_word(input logic [15:0] sync, input logic [15:0] cnt, input logic [15:0] len);
        header_word = '0;
        header_word[SYNC_LSB +: 16] = sync;
        header_word[CNT_LSB +: 16] = cnt;
        header_word[LEN_LSB +: 16] = len;
    endfunction
    function automatic logic [63:0] trailer_word(input logic [15:0] sync, input logic [15:0] cnt, input logic [31:0] csum);
        trailer_word = '0;
        trailer_word[SYNC_LSB +: 16] = sync;
        trailer_word[CNT_LSB +: 16] = cnt;
        trailer_word[CSUM_LSB +: 32] = csum;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty/fill flags and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_wr, do_rd;
    assign do_rd = rd && !empty;
    // a pop in the same cycle frees the slot, so a write into a full FIFO still lands
    assign do_wr = wr && (!full || do_rd);
    assign full  = fill[AW];
    assign empty = fill == '0;
    assign dout  = mem[rp];
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            fill <= '0;
        end else if (flush) begin
            wp   <= '0;
            rp   <= '0;
            fill <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            fill <= fill + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end
endmodule

// File: rtl/upload_packer.sv
// upload_packer: frames the upload switcher stream into header / payload / checksum-trailer packets
// behind a valid/ready output register.
module upload_packer
    import upload_pkg::*;
#(
    parameter int          FRAME_WORDS = 256,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] HDR_SYNC    = HDR_SYNC_DEF,
    parameter logic [15:0] TRL_SYNC    = TRL_SYNC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [63:0] data_in,
    input  logic        data_valid_i,
    input  logic        ready_i,
    output logic [63:0] data_out,
    output logic        data_valid_o,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] frame_cnt
);
    localparam logic [15:0] FW = 16'(FRAME_WORDS);
    localparam int AW = $clog2(FIFO_DEPTH);
    state_t state, nstate;
    logic [15:0] acc_cnt, pay_cnt;
    logic [31:0] csum, csum_next;
    logic [63:0] fifo_q;
    logic [AW:0] fill;
    logic full, empty, xfer, accept, pop, last, flush;
    assign xfer      = data_valid_o && ready_i;
    assign accept    = state != IDLE && data_valid_i && acc_cnt < FW;
    assign last      = state == PAYLOAD && xfer && pay_cnt == FW - 16'd1;
    // refill the output register as the header or a payload word leaves, or when it sits empty
    assign pop       = !empty && !last && (state == HEADER ? xfer : state == PAYLOAD && (!data_valid_o || ready_i));
    assign flush     = state == DONE && fill != '0;
    assign csum_next = csum ^ data_out[63:32] ^ data_out[31:0];
    sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .wr    (accept),
        .din   (data_in),
        .rd    (pop),
        .dout  (fifo_q),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = frame_start ? HEADER : IDLE;
            HEADER:  nstate = xfer ? PAYLOAD : HEADER;
            PAYLOAD: nstate = last ? TRAILER : PAYLOAD;
            TRAILER: nstate = xfer ? DONE : TRAILER;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out     <= '0;
            data_valid_o <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
            frame_cnt    <= '0;
            acc_cnt      <= '0;
            pay_cnt      <= '0;
            csum         <= '0;
        end else begin
            frame_done <= state == TRAILER && xfer;
            overflow   <= overflow || (accept && full && !pop);
            if (state == IDLE && frame_start) begin
                data_out     <= header_word(HDR_SYNC, frame_cnt, FW);
                data_valid_o <= 1'b1;
                acc_cnt      <= '0;
                pay_cnt      <= '0;
                csum         <= '0;
            end else begin
                if (accept) acc_cnt <= acc_cnt + 16'd1;
                if (state == PAYLOAD && xfer) begin
                    pay_cnt <= pay_cnt + 16'd1;
                    csum    <= csum_next;
                end
                if (last) begin
                    data_out     <= trailer_word(TRL_SYNC, frame_cnt, csum_next);
                    data_valid_o <= 1'b1;
                end else if (pop) begin
                    data_out     <= fifo_q;
                    data_valid_o <= 1'b1;
                end else if (xfer) begin
                    data_valid_o <= 1'b0;
                end
            end
            if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: doc/upload_packer.md
# upload_packer

Frames the 64-bit spectrum stream leaving the dual-channel upload switcher into self-describing packets for host upload. A trigger pulse arms one frame; the block then emits a header word, exactly `FRAME_WORDS` payload words taken through a small internal FIFO, and a trailer word carrying an XOR checksum. Output uses a valid/ready handshake, so the host-side interface can apply backpressure.

## Interface
Parameters:
- `FRAME_WORDS`, default 256: payload words per frame, range 1..65535.
- `FIFO_DEPTH`, default 16: payload FIFO depth in words; must be a power of 2, minimum 4.
- `HDR_SYNC`, default 16'hA55A: header sync pattern.
- `TRL_SYNC`, default 16'h5AA5: trailer sync pattern.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: single-cycle pulse that arms one frame. It is the same pulse that drives the switcher's `trigger_start`.
- `data_in` in 64: payload word from the upload switcher.
- `data_valid_i` in 1: `data_in` is valid this cycle. There is no backpressure toward upstream.
- `ready_i` in 1: host side accepts `data_out` this cycle.
- `data_out` out 64: packet word, registered.
- `data_valid_o` out 1: `data_out` is valid, registered.
- `frame_done` out 1: one-cycle pulse after the trailer transfers.
- `overflow` out 1: sticky. Set when a payload word is dropped because the FIFO is full. Cleared only by reset.
- `frame_cnt` out 16: index of the current or most recent frame.

## Operation
- Transfer rule: a word transfers when `data_valid_o && ready_i`. While `data_valid_o=1 && ready_i=0`, `data_out` holds stable.
- FSM states are IDLE, HEADER, PAYLOAD, TRAILER, DONE.
- IDLE:
  - `frame_start=1` moves to HEADER.
  - Incoming words are ignored: not written, not counted, no overflow.
- HEADER:
  - Present `{HDR_SYNC, frame_cnt, FRAME_WORDS[15:0], 16'h0000}`.
  - Move to PAYLOAD on transfer.
- Input side, active in any non-IDLE state:
  - A `data_valid_i` word is written while accepted-count < `FRAME_WORDS`.
  - Each write increments accepted-count.
  - Words beyond `FRAME_WORDS` are discarded silently.
  - A word arriving when the FIFO is full (and not being popped that cycle) is dropped, `overflow` is set, and accepted-count still increments, so framing cannot stall.
- PAYLOAD:
  - Pop the FIFO into the output register when the output register is empty or transferring, and the FIFO is not empty.
  - Checksum is a 32-bit register, cleared on entering HEADER. On each payload transfer: `csum ^= data_out[63:32] ^ data_out[31:0]`.
  - Count transferred payload words.
  - After the `FRAME_WORDS`-th transfer, move to TRAILER.
  - Dropped words are never emitted. If the frame is short, PAYLOAD waits for input indefinitely; the host timeout resolves this.
- TRAILER:
  - Present `{TRL_SYNC, frame_cnt, csum}`, where `csum` includes the final payload word.
  - Move to DONE on transfer.
- DONE:
  - Pulse `frame_done`, increment `frame_cnt` (wraps 16'hFFFF to 0), flush any residual FIFO content, return to IDLE.
- `frame_start` while not in IDLE is ignored: no re-arm, no counter change.

## Timing
- Reset values: `data_out`=0, `data_valid_o`=0, `frame_done`=0, `overflow`=0, `frame_cnt`=0. FSM is IDLE, FIFO is empty, counters and checksum are 0.
- `frame_start` sampled at edge E: header is valid on `data_out` from the cycle after E.
- A word with `data_valid_i` in the same cycle as `frame_start` is not accepted; the first acceptable word is in cycle E+1.
- First-word latency: a word written at edge N is on `data_out` no earlier than after edge N+1.
- With `ready_i` held high, the output can sustain 1 word per cycle. Minimum frame length is `FRAME_WORDS`+2 transfer cycles, plus 1 cycle for DONE.
- Simultaneous FIFO write and pop when full: the write succeeds and no overflow is flagged.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous) and the partial frame is abandoned. After `rst_n` deasserts, nothing is emitted until the next `frame_start`.

## Structure
- A shared package `upload_pkg` holds:
  - `HDR_SYNC` and `TRL_SYNC` defaults.
  - The FSM state enum.
  - Header/trailer field-position constants, shared with the host decoder.
- One sub-module, `sync_fifo`:
  - Parameterised width and depth.
  - Outputs: full, empty, fill count.
  - Async active-low reset plus a synchronous flush input.
- Everything else lives in `upload_packer`: FSM, counters, checksum, output register.

## Test plan
- Basic frame, `FRAME_WORDS=4`, `ready_i=1`. Pulse `frame_start`, then feed 1,2,3,4 on consecutive cycles. Expect: header `A55A_0000_0004_0000`, payload 1,2,3,4, trailer `5AA5_0000_00000004` (1^2^3^4=4), `frame_done` one cycle, `frame_cnt`=1.
- Backpressure. Toggle `ready_i` 1/0 every cycle during the payload. Expect no word duplicated or lost and `data_out` stable in every `ready_i=0` cycle.
- Overflow. Hold `ready_i=0` with `FIFO_DEPTH=4` and feed 6 words. Expect `overflow` set on the 5th word, exactly 4 payload words emitted after `ready_i` returns high, and still waiting for 2 more.
- Excess input. Feed `FRAME_WORDS`+3 words. Expect the extra 3 discarded, `overflow`=0, trailer checksum covering only the first `FRAME_WORDS` words.
- Ignored events. Assert `frame_start` mid-frame, and `data_valid_i` in IDLE and in the `frame_start` cycle. Expect none to affect the output, counters or `frame_cnt`.
- Reset mid-payload. Assert `rst_n` low during the 2nd payload word. Expect all outputs 0 immediately; after release, the next frame starts cleanly with `frame_cnt`=0.
